// File: rtl/regbank_pkg.sv
// Shared defaults and PC index derivation for the register bank and its
// neighbours in decode and writeback. Optional forwarding: REGBANK_BYPASS_EN.
package regbank_pkg;

    localparam int unsigned DEF_BITWIDTH = 32;
    localparam int unsigned DEF_DEPTH    = 16;

    // The PC always occupies the top index of the register file.
    function automatic int unsigned pc_idx(input int unsigned depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/regbank_rdport.sv
// One registered read port: address decode, PC select, optional write bypass
// (REGBANK_BYPASS_EN) and output flops. Outputs hold while rd_en is low.
module regbank_rdport
    import regbank_pkg::*;
#(
    parameter  int unsigned BITWIDTH = DEF_BITWIDTH,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic [BITWIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]    pend,
    input  logic [DEPTH-1:0]    pend_next,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [BITWIDTH-1:0] wdata,
    input  logic [BITWIDTH-1:0] pc_in,
    output logic [BITWIDTH-1:0] rdata,
    output logic                rhaz
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(pc_idx(DEPTH));

    logic [BITWIDTH-1:0] sel_data;
    logic                sel_haz;

`ifdef REGBANK_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = we && (waddr == raddr);
`else
    logic unused_bypass;
    assign unused_bypass = ^{pend_next, we, waddr, wdata};
`endif

    always_comb begin
        sel_data = regs[raddr];
        sel_haz  = pend[raddr];
`ifdef REGBANK_BYPASS_EN
        // Forwarded hazard comes from the updated vector so a same-cycle
        // re-mark by PEND_SET survives the write.
        if (bypass_hit) begin
            sel_data = wdata;
            sel_haz  = pend_next[raddr];
        end
`endif
        if (raddr == PC_ADDR) begin
            sel_data = pc_in;
            sel_haz  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rhaz  <= 1'b0;
        end else if (rd_en) begin
            rdata <= sel_data;
            rhaz  <= sel_haz;
        end
    end

endmodule

// File: rtl/regbank.sv
// ARM register bank: DEPTH-1 general registers, PC read from PC_IN, two
// registered read ports and a pending-load scoreboard. Bypass: REGBANK_BYPASS_EN.
module regbank
    import regbank_pkg::*;
#(
    parameter  int unsigned BITWIDTH = DEF_BITWIDTH,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RD_EN,
    input  logic [ADDR_W-1:0]   RADDR_A,
    input  logic [ADDR_W-1:0]   RADDR_B,
    output logic [BITWIDTH-1:0] RDATA_A,
    output logic [BITWIDTH-1:0] RDATA_B,
    output logic                RHAZ_A,
    output logic                RHAZ_B,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   WADDR,
    input  logic [BITWIDTH-1:0] WDATA,
    input  logic                PEND_SET,
    input  logic [ADDR_W-1:0]   PEND_ADDR,
    input  logic [BITWIDTH-1:0] PC_IN,
    output logic                PEND_ANY
);

    localparam int unsigned       PC_IDX  = pc_idx(DEPTH);
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    // No handshake: every cycle accepts one write, one pend-set and two reads.
    logic [BITWIDTH-1:0] reg_view [DEPTH];
    logic [DEPTH-1:0]    pend;
    logic [DEPTH-1:0]    pend_next;

    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_reg
        logic [BITWIDTH-1:0] q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                q <= '0;
            end else if (WE && (WADDR == ADDR_W'(g))) begin
                q <= WDATA;
            end
        end
        assign reg_view[g] = q;
    end

    // The PC slot has no storage; the read ports substitute PC_IN for it.
    assign reg_view[PC_IDX] = '0;

    // Clear on write first, then set, so a same-cycle set wins.
    always_comb begin
        pend_next = pend;
        if (WE) begin
            pend_next[WADDR] = 1'b0;
        end
        if (PEND_SET && (PEND_ADDR != PC_ADDR)) begin
            pend_next[PEND_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend     <= '0;
            PEND_ANY <= 1'b0;
        end else begin
            pend     <= pend_next;
            PEND_ANY <= |pend_next;
        end
    end

    regbank_rdport #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (DEPTH)
    ) u_port_a (
        .clk       (CLK),
        .rst       (RST),
        .rd_en     (RD_EN),
        .raddr     (RADDR_A),
        .regs      (reg_view),
        .pend      (pend),
        .pend_next (pend_next),
        .we        (WE),
        .waddr     (WADDR),
        .wdata     (WDATA),
        .pc_in     (PC_IN),
        .rdata     (RDATA_A),
        .rhaz      (RHAZ_A)
    );

    regbank_rdport #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (DEPTH)
    ) u_port_b (
        .clk       (CLK),
        .rst       (RST),
        .rd_en     (RD_EN),
        .raddr     (RADDR_B),
        .regs      (reg_view),
        .pend      (pend),
        .pend_next (pend_next),
        .we        (WE),
        .waddr     (WADDR),
        .wdata     (WDATA),
        .pc_in     (PC_IN),
        .rdata     (RDATA_B),
        .rhaz      (RHAZ_B)
    );

endmodule

// File: tb/tb_regbank.sv
// Directed bench for regbank: a 16x32 instance and a 32x64 instance, each with
// an expected-response queue popped by a monitor one cycle after issue.
module tb_regbank;

    localparam int W = 131;  // {rdata_a[63:0], rdata_b[63:0], rhaz_a, rhaz_b, pend_any}

`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16 x 32 instance
    logic        rst0, rd_en0, we0, pend_set0;
    logic [3:0]  raddr_a0, raddr_b0, waddr0, pend_addr0;
    logic [31:0] wdata0, pc_in0, rdata_a0, rdata_b0;
    logic        rhaz_a0, rhaz_b0, pend_any0;

    // 32 x 64 instance
    logic        rst1, rd_en1, we1, pend_set1;
    logic [4:0]  raddr_a1, raddr_b1, waddr1, pend_addr1;
    logic [63:0] wdata1, pc_in1, rdata_a1, rdata_b1;
    logic        rhaz_a1, rhaz_b1, pend_any1;

    regbank #(.BITWIDTH(32), .DEPTH(16)) dut0 (
        .CLK(clk), .RST(rst0), .RD_EN(rd_en0),
        .RADDR_A(raddr_a0), .RADDR_B(raddr_b0),
        .RDATA_A(rdata_a0), .RDATA_B(rdata_b0),
        .RHAZ_A(rhaz_a0), .RHAZ_B(rhaz_b0),
        .WE(we0), .WADDR(waddr0), .WDATA(wdata0),
        .PEND_SET(pend_set0), .PEND_ADDR(pend_addr0),
        .PC_IN(pc_in0), .PEND_ANY(pend_any0)
    );

    regbank #(.BITWIDTH(64), .DEPTH(32)) dut1 (
        .CLK(clk), .RST(rst1), .RD_EN(rd_en1),
        .RADDR_A(raddr_a1), .RADDR_B(raddr_b1),
        .RDATA_A(rdata_a1), .RDATA_B(rdata_b1),
        .RHAZ_A(rhaz_a1), .RHAZ_B(rhaz_b1),
        .WE(we1), .WADDR(waddr1), .WDATA(wdata1),
        .PEND_SET(pend_set1), .PEND_ADDR(pend_addr1),
        .PC_IN(pc_in1), .PEND_ANY(pend_any1)
    );

    // Scoreboard state
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] e0, e1;
    logic issue0 = 1'b0, issue1 = 1'b0;
    logic issued0 = 1'b0, issued1 = 1'b0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) begin
        issued0 <= issue0;
        issued1 <= issue1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare registered outputs mid-cycle after each checked edge.
    always @(negedge clk) begin
        if (issued0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d0_queue: got empty expected entry");
            end else begin
                e0 = exp0_q.pop_front();
                check("d0_rdata_a", {32'b0, rdata_a0}, e0[130:67]);
                check("d0_rdata_b", {32'b0, rdata_b0}, e0[66:3]);
                check("d0_rhaz_a", {63'b0, rhaz_a0}, {63'b0, e0[2]});
                check("d0_rhaz_b", {63'b0, rhaz_b0}, {63'b0, e0[1]});
                check("d0_pend_any", {63'b0, pend_any0}, {63'b0, e0[0]});
            end
        end
        if (issued1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1_queue: got empty expected entry");
            end else begin
                e1 = exp1_q.pop_front();
                check("d1_rdata_a", rdata_a1, e1[130:67]);
                check("d1_rdata_b", rdata_b1, e1[66:3]);
                check("d1_rhaz_a", {63'b0, rhaz_a1}, {63'b0, e1[2]});
                check("d1_rhaz_b", {63'b0, rhaz_b1}, {63'b0, e1[1]});
                check("d1_pend_any", {63'b0, pend_any1}, {63'b0, e1[0]});
            end
        end
    end

    // Driver tasks
    task automatic idle0();
        rst0 = 1'b0; rd_en0 = 1'b0; we0 = 1'b0; pend_set0 = 1'b0;
        raddr_a0 = '0; raddr_b0 = '0; waddr0 = '0; pend_addr0 = '0;
        wdata0 = '0; pc_in0 = '0;
    endtask

    task automatic idle1();
        rst1 = 1'b0; rd_en1 = 1'b0; we1 = 1'b0; pend_set1 = 1'b0;
        raddr_a1 = '0; raddr_b1 = '0; waddr1 = '0; pend_addr1 = '0;
        wdata1 = '0; pc_in1 = '0;
    endtask

    task automatic step0(input bit chk, input logic [31:0] ea, input logic [31:0] eb,
                         input bit ha, input bit hb, input bit pa);
        issue0 = chk;
        if (chk) exp0_q.push_back({32'b0, ea, 32'b0, eb, ha, hb, pa});
        @(negedge clk);
        issue0 = 1'b0;
        idle0();
    endtask

    task automatic step1(input bit chk, input logic [63:0] ea, input logic [63:0] eb,
                         input bit ha, input bit hb, input bit pa);
        issue1 = chk;
        if (chk) exp1_q.push_back({ea, eb, ha, hb, pa});
        @(negedge clk);
        issue1 = 1'b0;
        idle1();
    endtask

    task automatic rd0(input logic [3:0] a, input logic [3:0] b);
        rd_en0 = 1'b1; raddr_a0 = a; raddr_b0 = b;
    endtask

    task automatic rd1(input logic [4:0] a, input logic [4:0] b);
        rd_en1 = 1'b1; raddr_a1 = a; raddr_b1 = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle0();
        idle1();
        rst1 = 1'b1;
        @(negedge clk);

        // 16 x 32: reset, then PC and general reads
        rst0 = 1'b1;
        step0(1, 32'h0, 32'h0, 0, 0, 0);
        rd0(4'd3, 4'd15); pc_in0 = 32'h0000_1008;
        step0(1, 32'h0, 32'h0000_1008, 0, 0, 0);
        // RD_EN low: outputs hold despite new addresses and PC_IN
        raddr_a0 = 4'd5; raddr_b0 = 4'd7; pc_in0 = 32'h9999;
        step0(1, 32'h0, 32'h0000_1008, 0, 0, 0);

        // Same-cycle write/read of r5
        we0 = 1'b1; waddr0 = 4'd5; wdata0 = 32'hDEAD_BEEF; rd0(4'd5, 4'd5);
        step0(1, BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, 0, 0, 0);
        rd0(4'd5, 4'd3);
        step0(1, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);

        // Pending load on r2, completed by writeback
        pend_set0 = 1'b1; pend_addr0 = 4'd2;
        step0(0, 32'h0, 32'h0, 0, 0, 0);
        rd0(4'd2, 4'd5);
        step0(1, 32'h0, 32'hDEAD_BEEF, 1, 0, 1);
        we0 = 1'b1; waddr0 = 4'd2; wdata0 = 32'h55;
        step0(0, 32'h0, 32'h0, 0, 0, 0);
        rd0(4'd2, 4'd15); pc_in0 = 32'h0000_1008;
        step0(1, 32'h55, 32'h0000_1008, 0, 0, 0);

        // Writeback to a pending register with a same-cycle read
        pend_set0 = 1'b1; pend_addr0 = 4'd4;
        step0(0, 32'h0, 32'h0, 0, 0, 0);
        we0 = 1'b1; waddr0 = 4'd4; wdata0 = 32'h77; rd0(4'd4, 4'd4);
        step0(1, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, !BYP, !BYP, 0);

        // Write and pend-set on r7 in one cycle: set wins
        we0 = 1'b1; waddr0 = 4'd7; wdata0 = 32'hA5A5; pend_set0 = 1'b1; pend_addr0 = 4'd7;
        rd0(4'd7, 4'd7);
        step0(1, BYP ? 32'hA5A5 : 32'h0, BYP ? 32'hA5A5 : 32'h0, BYP, BYP, 1);
        rd0(4'd7, 4'd2);
        step0(1, 32'hA5A5, 32'h55, 1, 0, 1);
        we0 = 1'b1; waddr0 = 4'd7; wdata0 = 32'hA5A5;
        step0(0, 32'h0, 32'h0, 0, 0, 0);

        // Write and pend-set to PC are dropped; PC reads return PC_IN
        we0 = 1'b1; waddr0 = 4'd15; wdata0 = 32'h1234; pend_set0 = 1'b1; pend_addr0 = 4'd15;
        rd0(4'd15, 4'd15); pc_in0 = 32'h40;
        step0(1, 32'h40, 32'h40, 0, 0, 0);
        rd0(4'd5, 4'd2);
        step0(1, 32'hDEAD_BEEF, 32'h55, 0, 0, 0);
        rd0(4'd7, 4'd4);
        step0(1, 32'hA5A5, 32'h77, 0, 0, 0);
        rd0(4'd14, 4'd3);
        step0(1, 32'h0, 32'h0, 0, 0, 0);

        // Pending r1, then reset overriding read, write and pend-set
        pend_set0 = 1'b1; pend_addr0 = 4'd1; rd0(4'd1, 4'd15); pc_in0 = 32'h40;
        step0(1, 32'h0, 32'h40, 0, 0, 1);
        rst0 = 1'b1; rd0(4'd1, 4'd5); we0 = 1'b1; waddr0 = 4'd5; wdata0 = 32'hFFFF;
        pend_set0 = 1'b1; pend_addr0 = 4'd3;
        step0(1, 32'h0, 32'h0, 0, 0, 0);
        rd0(4'd5, 4'd1);
        step0(1, 32'h0, 32'h0, 0, 0, 0);

        // 32 x 64: reset, pending r30, reset overrides
        rst1 = 1'b1;
        step1(1, 64'h0, 64'h0, 0, 0, 0);
        we1 = 1'b1; waddr1 = 5'd30; wdata1 = 64'h0123_4567_89AB_CDEF;
        pend_set1 = 1'b1; pend_addr1 = 5'd30;
        step1(0, 64'h0, 64'h0, 0, 0, 0);
        rd1(5'd30, 5'd31); pc_in1 = 64'hFEDC_0000_0000_1000;
        step1(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_0000_0000_1000, 1, 0, 1);
        pend_set1 = 1'b1; pend_addr1 = 5'd1;
        step1(0, 64'h0, 64'h0, 0, 0, 0);
        rst1 = 1'b1; rd1(5'd30, 5'd1); we1 = 1'b1; waddr1 = 5'd30; wdata1 = '1;
        pend_set1 = 1'b1; pend_addr1 = 5'd2;
        step1(1, 64'h0, 64'h0, 0, 0, 0);
        rd1(5'd30, 5'd1);
        step1(1, 64'h0, 64'h0, 0, 0, 0);
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 64'hAAAA_BBBB_CCCC_DDDD; rd1(5'd0, 5'd30);
        step1(1, BYP ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h0, 64'h0, 0, 0, 0);
        rd1(5'd0, 5'd0);
        step1(1, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d/%0d left expected 0/0", exp0_q.size(), exp1_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank.md
# regbank

Parameterised ARM register bank that replaces the bare 16:1 register read multiplexer with storage, two registered read ports, one write port and a pending-load scoreboard. It sits between the decode stage, which issues reads and marks load destinations pending, and the writeback stage, which writes results and clears pending bits. The top index is the PC and always reads the externally supplied PC value.

## Interface
- BITWIDTH, 32, data width of every register.
- DEPTH, 16, number of registers; power of two, minimum 4; ADDR_W = $clog2(DEPTH) is a localparam; PC_IDX = DEPTH-1.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- RD_EN  in  1  read enable for both ports; when low, RDATA_x and RHAZ_x hold.
- RADDR_A  in  ADDR_W  port A read address.
- RADDR_B  in  ADDR_W  port B read address.
- RDATA_A  out  BITWIDTH  port A data, registered.
- RDATA_B  out  BITWIDTH  port B data, registered.
- RHAZ_A  out  1  port A source was pending at read, registered.
- RHAZ_B  out  1  port B source was pending at read, registered.
- WE  in  1  write enable.
- WADDR  in  ADDR_W  write address.
- WDATA  in  BITWIDTH  write data.
- PEND_SET  in  1  mark PEND_ADDR pending (load in flight).
- PEND_ADDR  in  ADDR_W  register to mark pending.
- PC_IN  in  BITWIDTH  value returned for reads of PC_IDX.
- PEND_ANY  out  1  OR of all pending bits, driven directly from flops.

## Operation
- Storage: DEPTH-1 general registers (index 0..DEPTH-2). PC_IDX has no storage.
- Write: WE=1 and WADDR≠PC_IDX → reg[WADDR] <= WDATA. Writes to PC_IDX are dropped and only clear its pending bit (always 0 anyway).
- Pending vector pend[DEPTH-1:0]:
  - WE=1 clears pend[WADDR].
  - PEND_SET=1 sets pend[PEND_ADDR]; PEND_ADDR=PC_IDX is ignored.
  - If both hit the same index in one cycle, set wins (a new load issued after the previous one completes).
- Read with RD_EN=1, per port x:
  - RADDR_x=PC_IDX → RDATA_x <= PC_IN, RHAZ_x <= 0.
  - Otherwise RDATA_x <= reg[RADDR_x] and RHAZ_x <= pend[RADDR_x], as modified by the bypass rule below.
- Both ports are independent. The same address on both ports returns identical data.
- Reset: all registers, pend, RDATA_A, RDATA_B, RHAZ_A, RHAZ_B and PEND_ANY go to 0. Reset overrides WE, PEND_SET and RD_EN in the same cycle. A load pending when reset hits is forgotten.

## Timing
- Read latency 1 cycle: the address is sampled at edge N and the data is valid after edge N.
- Write visible to storage after its edge. Same-cycle read visibility is set by the configuration below.
- PEND_ANY reflects pend after the edge that updated it. There is no combinational path from inputs.
- There are no stalls or back-pressure. Every cycle accepts one write, one pend-set and two reads.

## Configuration
- REGBANK_BYPASS_EN defined: forwarding is enabled. A read with WE=1, WADDR=RADDR_x≠PC_IDX in the same cycle returns WDATA, and RHAZ_x <= pend_next[RADDR_x]. The write clears the hazard unless a same-cycle PEND_SET re-marks that register.
- Not defined: the same-cycle read returns the old reg[RADDR_x], and RHAZ_x <= current pend[RADDR_x]. The new value is visible from the next read.

## Structure
- Shared package regbank_pkg holds the BITWIDTH/DEPTH defaults and the PC_IDX derivation function, reused by decode and writeback.
- One sub-module, regbank_rdport, is instantiated twice. It contains the address decode, the PC select, the optional bypass compare and the output flops. The top holds storage and pend.

## Test plan
- Reset then read A=3, B=PC_IDX with PC_IN=0x0000_1008 → RDATA_A=0, RDATA_B=0x0000_1008, RHAZ both 0.
- Write r5=0xDEADBEEF with a same-cycle read A=5 → with REGBANK_BYPASS_EN RDATA_A=0xDEADBEEF; without it, RDATA_A=0 and the next-cycle read gives 0xDEADBEEF.
- PEND_SET r2, then read A=2 → RHAZ_A=1 and PEND_ANY=1. WE r2=0x55 → the next read gives RHAZ_A=0, RDATA_A=0x55 and PEND_ANY=0.
- Same cycle WE r7 and PEND_SET r7 → pend[7]=1 and r7 holds the new data; the next read gives RHAZ_A=1.
- WE to PC_IDX with 0x1234, then read PC_IDX with PC_IN=0x40 → RDATA=0x40, and no general register changes.
- PEND_SET r1, assert RST with RD_EN=1 and WE=1 → after the edge all outputs are 0 and PEND_ANY=0. Repeat with DEPTH=32, BITWIDTH=64 on r30.
